// File: rtl/ifu_handshake_fetch_if.sv
// Bundle of handshake signals between the fetch unit, instruction memory,
// the redirect source and the IDU.
// Optional feature macro: IFU_MISALIGN_CHECK_EN adds the fetch_fault signal.
interface ifu_handshake_fetch_if #(
  parameter int XLEN   = 32,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_resp_valid;
  logic [INST_W-1:0] mem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic              fetch_fault;
`endif

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst, pc
`ifdef IFU_MISALIGN_CHECK_EN
    , output fetch_fault
`endif
  );

  // Environment side: memory, redirect source and IDU
  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst, pc
`ifdef IFU_MISALIGN_CHECK_EN
    , input fetch_fault
`endif
  );
endinterface

// File: rtl/ifu_handshake_fetch.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time over a
// req/resp handshake and presents each instruction to the IDU over
// valid/ready. Redirects are accepted in every state; a response that was
// already in flight when the redirect came is discarded.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned-redirect fault path).
module ifu_handshake_fetch #(
  parameter int              XLEN     = 32,
  parameter int              INST_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ifu_handshake_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_inst_valid;
  logic              w_outstanding;
  logic [XLEN-1:0]   w_redirect_tgt;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  logic r_fault;
  logic r_fault_pend;   // misaligned redirect waiting for a stale response to drain
  logic w_misaligned;

  assign w_redirect_tgt = bus.redirect_pc;
  assign w_misaligned   = |bus.redirect_pc[1:0];
`else
  // Low two address bits of a redirect target are forced to zero
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  assign w_redirect_tgt = align_pc(bus.redirect_pc);
`endif

  // A request is still owed a response after this edge if it is being accepted
  // now, or if we are waiting and the response is not arriving this cycle.
  always_comb begin
    w_outstanding = 1'b0;
    case (r_state)
      S_REQ:          w_outstanding = bus.mem_req_ready;
      S_WAIT, S_DROP: w_outstanding = !bus.mem_resp_valid;
      default:        w_outstanding = 1'b0;
    endcase
  end

  // Fetch FSM with PC, instruction and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      r_fault      <= 1'b0;
      r_fault_pend <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Redirect overrides every transition; in HOLD with inst_ready the
      // handshake still completes but the redirect target replaces pc+step.
      r_pc         <= w_redirect_tgt;
      r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      r_fault      <= 1'b0;
      r_fault_pend <= 1'b0;
      if (w_misaligned) begin
        if (w_outstanding) begin
          r_state      <= S_DROP;
          r_fault_pend <= 1'b1;
        end else begin
          r_state      <= S_HOLD;
          r_inst       <= NOP_INST;
          r_inst_valid <= 1'b1;
          r_fault      <= 1'b1;
        end
      end else begin
        r_state <= w_outstanding ? S_DROP : S_REQ;
      end
`else
      r_state <= w_outstanding ? S_DROP : S_REQ;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_inst       <= bus.mem_resp_data;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= r_pc + XLEN'(PC_STEP);
            r_state      <= S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
            r_fault      <= 1'b0;
`endif
          end
        end
        S_DROP: begin
          if (bus.mem_resp_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
            if (r_fault_pend) begin
              r_inst       <= NOP_INST;
              r_inst_valid <= 1'b1;
              r_fault      <= 1'b1;
              r_fault_pend <= 1'b0;
              r_state      <= S_HOLD;
            end else begin
              r_state <= S_REQ;
            end
`else
            r_state <= S_REQ;
`endif
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // A response is only legal while a request is owed one (WAIT or DROP)
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_resp_valid)
      assert (r_state == S_WAIT || r_state == S_DROP);
  end

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = r_pc;
  assign bus.inst_valid    = r_inst_valid;
  assign bus.inst          = r_inst;
  assign bus.pc            = r_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  assign bus.fetch_fault   = r_fault;
`endif

endmodule

// File: tb/tb_ifu_handshake_fetch.sv
// Testbench for ifu_handshake_fetch: directed scenarios plus randomized
// traffic checked against a transaction-level model (expected PC stream,
// address-derived memory contents, single-outstanding memory responder).
`timescale 1ns/1ps
module tb_ifu_handshake_fetch;
  localparam int          XLEN     = 32;
  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_handshake_fetch_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

  ifu_handshake_fetch #(.XLEN(XLEN), .INST_W(INST_W), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // Memory content is a bijective scramble of the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // PC that a redirect to a leads to
  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  // Reset for n cycles with idle inputs, then release; model returns to reset
  task automatic apply_reset(input int n);
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.inst_ready = 1'b0;
    pend = 1'b0; pend_cnt = 0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    exp_pc = RESET_PC;
  endtask

  // One clock: drive inputs at the negedge, run the memory responder and the
  // PC-stream model, advance to the next negedge.
  task automatic cyc(input logic ir, input logic rdy, input logic rd, input logic [31:0] rpc);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = memf(pend_addr);
        pend = 1'b0;
      end
    end
    bus.mem_req_ready  = rdy;
    bus.inst_ready     = ir;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    if (bus.mem_req_valid && rdy) begin
      pend      = 1'b1;
      pend_cnt  = $urandom_range(lat_hi, lat_lo);
      pend_addr = bus.mem_req_addr;
    end
    if (rd) exp_pc = tgt(rpc);
    else if (bus.inst_valid && ir) exp_pc = exp_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic test_reset();
    lat_lo = 3; lat_hi = 3;
    apply_reset(2);
    n_cmp++; if (bus.pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, RESET_PC); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
    n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_req_valid: got %b want 1", bus.mem_req_valid); end
    n_cmp++; if (bus.mem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_req_addr: got %h want %h", bus.mem_req_addr, RESET_PC); end
`ifdef IFU_MISALIGN_CHECK_EN
    n_cmp++; if (bus.fetch_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", bus.fetch_fault); end
`endif
    // Mid-operation reset with a request in flight
    cyc(0, 0, 1, 32'h8000_0040);
    cyc(0, 1, 0, 32'h0);
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_wait: req_valid got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.pc !== 32'h8000_0040) begin n_bad++; $display("FAIL midrst_pc_before: got %h want 80000040", bus.pc); end
    apply_reset(1);
    n_cmp++; if (bus.pc !== RESET_PC) begin n_bad++; $display("FAIL midrst_pc: got %h want %h", bus.pc, RESET_PC); end
    n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_req_valid: got %b want 1", bus.mem_req_valid); end
    repeat (3) begin
      cyc(0, 0, 0, 32'h0);
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_inst: got %b want 0", bus.inst_valid); end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] seen_pc[$];
    int          seen_cyc[$];
    bit          first = 1'b1;
    lat_lo = 1; lat_hi = 1;
    apply_reset(2);
    for (int i = 0; i < 15 && seen_pc.size() < 3; i++) begin
      if (first && bus.mem_req_valid) begin
        first = 1'b0;
        n_cmp++; if (bus.mem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL seq_first_addr: got %h want %h", bus.mem_req_addr, RESET_PC); end
      end
      if (bus.inst_valid) begin
        seen_pc.push_back(bus.pc);
        seen_cyc.push_back(cyc_n);
        n_cmp++; if (bus.inst !== memf(bus.pc)) begin n_bad++; $display("FAIL seq_inst: got %h want %h", bus.inst, memf(bus.pc)); end
      end
      cyc(1, 1, 0, 32'h0);
    end
    n_cmp++;
    if (seen_pc.size() != 3) begin
      n_bad++; $display("FAIL seq_count: got %0d instructions want 3", seen_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (seen_pc[k] !== RESET_PC + 32'(4 * k)) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", k, seen_pc[k], RESET_PC + 32'(4 * k)); end
        if (k > 0) begin
          n_cmp++; if (seen_cyc[k] - seen_cyc[k-1] != 3) begin n_bad++; $display("FAIL seq_spacing%0d: got %0d want 3", k, seen_cyc[k] - seen_cyc[k-1]); end
        end
      end
    end
  endtask

  task automatic test_hold_stall();
    logic [31:0] cap_pc, cap_inst;
    lat_lo = 1; lat_hi = 1;
    apply_reset(2);
    for (int i = 0; i < 10 && !bus.inst_valid; i++) cyc(0, 1, 0, 32'h0);
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_first_inst: got %b want 1", bus.inst_valid); end
    cap_pc = bus.pc; cap_inst = bus.inst;
    repeat (5) begin
      cyc(0, 1, 0, 32'h0);
      n_cmp++; if (bus.inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", bus.inst_valid); end
      n_cmp++; if (bus.inst !== cap_inst) begin n_bad++; $display("FAIL stall_inst: got %h want %h", bus.inst, cap_inst); end
      n_cmp++; if (bus.pc !== cap_pc) begin n_bad++; $display("FAIL stall_pc: got %h want %h", bus.pc, cap_pc); end
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_req: got %b want 0", bus.mem_req_valid); end
    end
    cyc(1, 1, 0, 32'h0);
    n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== cap_pc + 32'd4) begin n_bad++; $display("FAIL stall_next_req: got %b/%h want 1/%h", bus.mem_req_valid, bus.mem_req_addr, cap_pc + 32'd4); end
    for (int i = 0; i < 10 && !bus.inst_valid; i++) cyc(0, 1, 0, 32'h0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.pc !== cap_pc + 32'd4) begin n_bad++; $display("FAIL stall_next_inst: got %b/%h want 1/%h", bus.inst_valid, bus.pc, cap_pc + 32'd4); end
  endtask

  task automatic test_redirect_wait();
    bit got = 1'b0;
    bit first = 1'b1;
    lat_lo = 4; lat_hi = 4;
    apply_reset(2);
    cyc(1, 1, 0, 32'h0);
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rw_in_wait: req_valid got %b want 0", bus.mem_req_valid); end
    cyc(1, 1, 1, 32'h8000_1000);
    for (int i = 0; i < 16 && !got; i++) begin
      n_cmp++; if (bus.mem_req_valid && pend) begin n_bad++; $display("FAIL rw_one_outstanding: req_valid got 1 want 0 while response owed"); end
      if (first && bus.mem_req_valid) begin
        first = 1'b0;
        n_cmp++; if (bus.mem_req_addr !== 32'h8000_1000) begin n_bad++; $display("FAIL rw_req_addr: got %h want 80001000", bus.mem_req_addr); end
      end
      if (bus.inst_valid) begin
        got = 1'b1;
        n_cmp++; if (bus.pc !== 32'h8000_1000) begin n_bad++; $display("FAIL rw_pc: got %h want 80001000", bus.pc); end
        n_cmp++; if (bus.inst !== memf(32'h8000_1000)) begin n_bad++; $display("FAIL rw_inst: got %h want %h", bus.inst, memf(32'h8000_1000)); end
      end
      cyc(1, 1, 0, 32'h0);
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rw_timeout: got no instruction want one within 16 cycles"); end
  endtask

  task automatic test_redirect_hold();
    lat_lo = 1; lat_hi = 1;
    apply_reset(2);
    for (int i = 0; i < 10 && !bus.inst_valid; i++) cyc(0, 1, 0, 32'h0);
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_bad++; $display("FAIL rh_hold: got %b want 1", bus.inst_valid); end
    cyc(1, 1, 1, 32'h8000_0100);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL rh_valid_drop: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rh_req: got %b/%h want 1/80000100", bus.mem_req_valid, bus.mem_req_addr); end
    for (int i = 0; i < 10 && !bus.inst_valid; i++) cyc(0, 1, 0, 32'h0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h8000_0100) begin n_bad++; $display("FAIL rh_inst: got %b/%h want 1/80000100", bus.inst_valid, bus.pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    lat_lo = 1; lat_hi = 1;
    apply_reset(2);
    cyc(1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 12 && addrs.size() < 2; i++) begin
      if (bus.mem_req_valid) addrs.push_back(bus.mem_req_addr);
      if (bus.inst_valid) begin
        n_cmp++; if (bus.pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_inst_pc: got %h want fffffffc", bus.pc); end
      end
      cyc(1, 1, 0, 32'h0);
    end
    n_cmp++;
    if (addrs.size() != 2) begin
      n_bad++; $display("FAIL wrap_count: got %0d requests want 2", addrs.size());
    end else begin
      n_cmp++; if (addrs[0] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr0: got %h want fffffffc", addrs[0]); end
      n_cmp++; if (addrs[1] !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_addr1: got %h want 00000000", addrs[1]); end
    end
  endtask

  task automatic test_misalign();
`ifdef IFU_MISALIGN_CHECK_EN
    bit got = 1'b0;
    lat_lo = 3; lat_hi = 3;
    apply_reset(2);
    cyc(0, 0, 1, 32'h8000_0002);
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_no_req: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0000_0013) begin n_bad++; $display("FAIL mis_nop: got %b/%h want 1/00000013", bus.inst_valid, bus.inst); end
    n_cmp++; if (bus.fetch_fault !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %b want 1", bus.fetch_fault); end
    n_cmp++; if (bus.pc !== 32'h8000_0002) begin n_bad++; $display("FAIL mis_pc: got %h want 80000002", bus.pc); end
    repeat (3) begin
      cyc(0, 1, 0, 32'h0);
      n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.fetch_fault !== 1'b1) begin n_bad++; $display("FAIL mis_hold: got req %b fault %b want 0/1", bus.mem_req_valid, bus.fetch_fault); end
    end
    cyc(1, 0, 0, 32'h0);
    n_cmp++; if (bus.fetch_fault !== 1'b0 || bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL mis_clear: got fault %b valid %b want 0/0", bus.fetch_fault, bus.inst_valid); end
    // Misaligned redirect while a request is outstanding drains via DROP first
    apply_reset(2);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 1, 32'h8000_0006);
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.inst_valid) begin
        got = 1'b1;
        n_cmp++; if (pend) begin n_bad++; $display("FAIL misd_order: got NOP with response still owed want drain first"); end
        n_cmp++; if (bus.inst !== 32'h0000_0013 || bus.fetch_fault !== 1'b1) begin n_bad++; $display("FAIL misd_nop: got %h/%b want 00000013/1", bus.inst, bus.fetch_fault); end
        n_cmp++; if (bus.pc !== 32'h8000_0006) begin n_bad++; $display("FAIL misd_pc: got %h want 80000006", bus.pc); end
      end else begin
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL misd_no_req: got %b want 0", bus.mem_req_valid); end
      end
      if (!got) cyc(0, 1, 0, 32'h0);
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL misd_timeout: got no NOP want one within 10 cycles"); end
`else
    lat_lo = 1; lat_hi = 1;
    apply_reset(2);
    cyc(0, 0, 1, 32'h8000_0002);
    n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL mis_aligned_req: got %b/%h want 1/80000000", bus.mem_req_valid, bus.mem_req_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL mis_no_inst: got %b want 0", bus.inst_valid); end
`endif
  endtask

  task automatic test_random();
    int hs = 0;
    lat_lo = 1; lat_hi = 4;
    apply_reset(2);
    for (int i = 0; i < 3000; i++) begin
      logic        ir, rdy, rd;
      logic [31:0] rpc;
      ir  = ($urandom_range(9, 0) < 7);
      rdy = ($urandom_range(9, 0) < 6);
      rd  = ($urandom_range(99, 0) < 6);
      rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if (bus.inst_valid) begin
        n_cmp++; if (bus.pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc @%0d: got %h want %h", cyc_n, bus.pc, exp_pc); end
        n_cmp++; if (bus.inst !== memf(exp_pc)) begin n_bad++; $display("FAIL rnd_inst @%0d: got %h want %h", cyc_n, bus.inst, memf(exp_pc)); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_req_in_hold @%0d: got 1 want 0", cyc_n); end
      end
      if (bus.mem_req_valid) begin
        n_cmp++; if (bus.mem_req_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc_n, bus.mem_req_addr, exp_pc); end
        n_cmp++; if (pend) begin n_bad++; $display("FAIL rnd_one_outstanding @%0d: got request want none while response owed", cyc_n); end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      n_cmp++; if (bus.fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rnd_fault @%0d: got %b want 0", cyc_n, bus.fetch_fault); end
`endif
      if (bus.inst_valid && ir && !rd) hs++;
      cyc(ir, rdy, rd, rpc);
    end
    n_cmp++; if (hs < 50) begin n_bad++; $display("FAIL rnd_progress: got %0d handshakes want at least 50", hs); end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
